// File: rtl/fail_chain_reader.sv
// Fail-bit scan chain readout: shifts the daisy-chained compare registers out
// through i_so, packs the bits MSB-first into words and hands them over valid/ready.
module fail_chain_reader #(
  parameter int CHAIN_LEN = 16,
  parameter int WORD_W    = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              i_start,
  input  logic              i_restore,
  output logic              o_busy,
  output logic              o_shift_mode,
  output logic              o_si,
  input  logic              i_so,
  output logic [WORD_W-1:0] o_word,
  output logic              o_word_valid,
  input  logic              i_word_ready,
  output logic              o_done,
  output logic              o_any_fail
);

  // state   | meaning
  // S_IDLE  | waiting for i_start, chain untouched
  // S_SHIFT | chain shifting, one bit sampled per edge
  // S_WAIT  | word presented, chain frozen until the consumer takes it

  localparam int BW = $clog2(CHAIN_LEN + 1);
  localparam int WW = $clog2(WORD_W + 1);

  localparam logic [BW-1:0] LAST_BIT  = BW'(CHAIN_LEN - 1);
  localparam logic [BW-1:0] ALL_BITS  = BW'(CHAIN_LEN);
  localparam logic [WW-1:0] LAST_SLOT = WW'(WORD_W - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_WAIT
  } state_t;

  state_t            state;
  logic [BW-1:0]     bit_cnt;
  logic [WW-1:0]     word_cnt;
  logic [WORD_W-1:0] shreg;
  logic [WORD_W-1:0] word_next;
  logic              r_restore;

  // The shift register is cleared at every word boundary, so a short final
  // word comes out right-aligned with zeros above it.
  assign word_next = WORD_W'({shreg, i_so});

  // Recirculating the tail bit in the same cycle keeps the chain intact.
  assign o_si = r_restore & i_so;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state        <= S_IDLE;
      bit_cnt      <= '0;
      word_cnt     <= '0;
      shreg        <= '0;
      r_restore    <= 1'b0;
      o_busy       <= 1'b0;
      o_shift_mode <= 1'b0;
      o_word       <= '0;
      o_word_valid <= 1'b0;
      o_done       <= 1'b0;
      o_any_fail   <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_start) begin
            state        <= S_SHIFT;
            o_busy       <= 1'b1;
            o_shift_mode <= 1'b1;
            o_any_fail   <= 1'b0;
            bit_cnt      <= '0;
            word_cnt     <= '0;
            shreg        <= '0;
            r_restore    <= i_restore;
          end
        end

        S_SHIFT: begin
          o_any_fail <= o_any_fail | i_so;
          bit_cnt    <= bit_cnt + 1'b1;
          if ((word_cnt == LAST_SLOT) || (bit_cnt == LAST_BIT)) begin
            o_word       <= word_next;
            o_word_valid <= 1'b1;
            o_shift_mode <= 1'b0;
            word_cnt     <= '0;
            shreg        <= '0;
            state        <= S_WAIT;
          end else begin
            word_cnt <= word_cnt + 1'b1;
            shreg    <= word_next;
          end
        end

        S_WAIT: begin
          if (o_word_valid && i_word_ready) begin
            o_word_valid <= 1'b0;
            if (bit_cnt == ALL_BITS) begin
              state  <= S_IDLE;
              o_busy <= 1'b0;
              o_done <= 1'b1;
            end else begin
              state        <= S_SHIFT;
              o_shift_mode <= 1'b1;
            end
          end
        end

        default: begin
          state        <= S_IDLE;
          o_busy       <= 1'b0;
          o_shift_mode <= 1'b0;
          o_word_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fail_chain_reader.sv
// Bench for fail_chain_reader: two instances (16/8 and 12/8) each driving a
// behavioural scan chain; words, timing and chain contents checked against a model.
module tb_fail_chain_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstn;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  // instance 0: CHAIN_LEN=16, WORD_W=8
  logic       start0, restore0, busy0, sm0, si0, so0, valid0, ready0, done0, af0;
  logic [7:0] word0;
  logic [15:0] chain0, load_val0;
  logic        load0;

  // instance 1: CHAIN_LEN=12, WORD_W=8
  logic       start1, restore1, busy1, sm1, si1, so1, valid1, ready1, done1, af1;
  logic [7:0] word1;
  logic [11:0] chain1, load_val1;
  logic        load1;

  assign so0 = chain0[15];
  assign so1 = chain1[11];

  always @(posedge clk) begin
    if (load0)    chain0 <= load_val0;
    else if (sm0) chain0 <= {chain0[14:0], si0};
    if (load1)    chain1 <= load_val1;
    else if (sm1) chain1 <= {chain1[10:0], si1};
  end

  fail_chain_reader #(.CHAIN_LEN(16), .WORD_W(8)) dut0 (
    .clk(clk), .rstn(rstn), .i_start(start0), .i_restore(restore0),
    .o_busy(busy0), .o_shift_mode(sm0), .o_si(si0), .i_so(so0),
    .o_word(word0), .o_word_valid(valid0), .i_word_ready(ready0),
    .o_done(done0), .o_any_fail(af0)
  );

  fail_chain_reader #(.CHAIN_LEN(12), .WORD_W(8)) dut1 (
    .clk(clk), .rstn(rstn), .i_start(start1), .i_restore(restore1),
    .o_busy(busy1), .o_shift_mode(sm1), .o_si(si1), .i_so(so1),
    .o_word(word1), .o_word_valid(valid1), .i_word_ready(ready1),
    .o_done(done1), .o_any_fail(af1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Word j of a CHAIN_LEN-bit chain read MSB first, W bits per word.
  function automatic logic [7:0] exp_word(input logic [31:0] v, input int len, input int w,
                                          input int j);
    int hi;
    int n;
    logic [31:0] mask;
    hi   = len - j * w;
    n    = (hi < w) ? hi : w;
    mask = (32'd1 << n) - 32'd1;
    return 8'((v >> (hi - n)) & mask);
  endfunction

  task automatic load_chain0(input logic [15:0] v);
    @(negedge clk);
    load_val0 = v;
    load0     = 1'b1;
    @(negedge clk);
    load0 = 1'b0;
  endtask

  task automatic load_chain1(input logic [11:0] v);
    @(negedge clk);
    load_val1 = v;
    load1     = 1'b1;
    @(negedge clk);
    load1 = 1'b0;
  endtask

  // Full readout on instance 0 with per-word stall counts and an optional
  // start/restore poke in the middle of the first word.
  task automatic read0(input logic [15:0] v, input bit r, input int st0, input int st1,
                       input bit poke);
    int t0;
    int stalls;
    int s;
    logic [7:0] ew;
    stalls = 0;
    @(negedge clk);
    start0   = 1'b1;
    restore0 = r;
    @(negedge clk);
    start0   = 1'b0;
    restore0 = ~r;
    t0 = cyc;
    check("busy_after_start", busy0, 1);
    for (int j = 0; j < 2; j++) begin
      ew = exp_word(v, 16, 8, j);
      for (int k = 0; k < 8; k++) begin
        check("shift_mode_in_shift", sm0, 1);
        check("valid_in_shift", valid0, 0);
        ready0 = 1'($urandom_range(0, 1));
        start0 = (poke && j == 0 && k == 3);
        @(posedge clk);
        @(negedge clk);
      end
      start0 = 1'b0;
      check("word_valid", valid0, 1);
      check("word_value", word0, ew);
      check("shift_mode_word_edge", sm0, 0);
      s = (j == 0) ? st0 : st1;
      stalls += s;
      ready0 = 1'b0;
      repeat (s) begin
        @(posedge clk);
        @(negedge clk);
        check("stall_valid", valid0, 1);
        check("stall_word", word0, ew);
        check("stall_shift_mode", sm0, 0);
      end
      ready0 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      ready0 = 1'b0;
    end
    check("done_pulse", done0, 1);
    check("busy_at_done", busy0, 0);
    check("valid_at_done", valid0, 0);
    check("done_latency", 32'(cyc - t0), 32'(16 + 2 + stalls));
    check("any_fail", af0, (v != 16'h0));
    @(posedge clk);
    @(negedge clk);
    check("done_one_cycle", done0, 0);
    check("chain_after", chain0, r ? v : 16'h0);
  endtask

  task automatic read1(input logic [11:0] v, input bit r);
    logic [7:0] got[$];
    int t0;
    int tdone;
    load_chain1(v);
    tdone = -1;
    @(negedge clk);
    start1   = 1'b1;
    restore1 = r;
    @(negedge clk);
    start1 = 1'b0;
    t0 = cyc;
    for (int i = 0; i < 40 && tdone < 0; i++) begin
      if (valid1) got.push_back(word1);
      if (done1) tdone = cyc - t0;
      if (tdone < 0) begin
        @(posedge clk);
        @(negedge clk);
      end
    end
    check("p12_done_latency", 32'(tdone), 32'(12 + 2));
    check("p12_word_count", 32'(got.size()), 2);
    for (int j = 0; j < 2 && j < got.size(); j++)
      check("p12_word", got[j], exp_word(v, 12, 8, j));
    check("p12_any_fail", af1, (v != 12'h0));
    check("p12_chain_after", chain1, r ? v : 12'h0);
  endtask

  task automatic reset_mid(input logic [15:0] v, input bit r);
    logic [15:0] m;
    load_chain0(v);
    @(negedge clk);
    start0   = 1'b1;
    restore0 = r;
    @(negedge clk);
    start0 = 1'b0;
    repeat (5) begin
      @(posedge clk);
      @(negedge clk);
    end
    // reset is sampled at the 6th edge; the chain still shifts at that edge
    rstn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy0, 0);
    check("rst_shift_mode", sm0, 0);
    check("rst_si", si0, 0);
    check("rst_word", word0, 0);
    check("rst_valid", valid0, 0);
    check("rst_done", done0, 0);
    check("rst_any_fail", af0, 0);
    rstn = 1'b1;
    m = r ? ((v << 6) | (v >> 10)) : (v << 6);
    check("rst_chain_partial", chain0, m);
    read0(m, 1'b1, 0, 0, 1'b0);
  endtask

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] v;
    bit r;
    rstn = 1'b0;
    start0 = 1'b0; restore0 = 1'b0; ready0 = 1'b0; load0 = 1'b0; load_val0 = '0;
    start1 = 1'b0; restore1 = 1'b0; ready1 = 1'b1; load1 = 1'b0; load_val1 = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", busy0, 0);
    check("reset_shift_mode", sm0, 0);
    check("reset_word", word0, 0);
    check("reset_valid", valid0, 0);
    check("reset_done", done0, 0);
    check("reset_any_fail", af0, 0);
    check("reset_valid_p12", valid1, 0);
    rstn = 1'b1;

    load_chain0(16'hA53C);
    read0(16'hA53C, 1'b0, 0, 0, 1'b0);
    load_chain0(16'hA53C);
    read0(16'hA53C, 1'b1, 0, 0, 1'b0);
    read0(16'hA53C, 1'b1, 0, 0, 1'b0);
    load_chain0(16'hA53C);
    read0(16'hA53C, 1'b0, 5, 0, 1'b0);
    load_chain0(16'h0000);
    read0(16'h0000, 1'b1, 0, 0, 1'b1);
    load_chain0(16'h8001);
    read0(16'h8001, 1'b1, 1, 2, 1'b1);
    reset_mid(16'hC3A5, 1'b1);
    reset_mid(16'h5A0F, 1'b0);

    read1(12'hFFF, 1'b0);
    read1(12'h9A5, 1'b1);

    for (int it = 0; it < 20; it++) begin
      v = 16'($urandom);
      r = 1'($urandom_range(0, 1));
      load_chain0(v);
      read0(v, r, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      if (it % 4 == 0) read1(12'($urandom), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
